// File: rtl/fitbit_display_sequencer.sv
// Display-channel sequencer: picks one of NUM_CH metric channels for the
// seven-segment driver, rotating every DWELL_SEC seconds in auto mode or on a
// button edge in manual mode. Also emits a once-per-second strobe and a
// one-cycle strobe whenever the shown channel changes.
module fitbit_display_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int TICK_DIV  = 100_000_000,
  parameter int DWELL_SEC = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      manual,
  input  logic                      next_btn,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic [NUM_CH-1:0]         ch_alt,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      disp_alt,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic                      sec_tick,
  output logic                      ch_change
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_W = $clog2(DWELL_SEC + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_SEC - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, AUTO, MANUAL} state_t;

  // channel k lives at ch_data[k*DATA_W +: DATA_W]; view it as a packed array
  logic [NUM_CH-1:0][DATA_W-1:0] ch_vec;
  assign ch_vec = ch_data;

  state_t            state_q,     state_d;
  logic [CH_W-1:0]   cur_ch_q,    cur_ch_d;
  logic [PS_W-1:0]   ps_q,        ps_d;
  logic [DW_W-1:0]   dwell_q,     dwell_d;
  logic              btn_q,       btn_d;
  logic              sec_tick_q,  sec_tick_d;
  logic              ch_change_q, ch_change_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_alt_q,  disp_alt_d;
  logic              adv;
  logic              btn_rise;

  assign btn_rise = next_btn & ~btn_q;

  // next-state: prescaler, mode FSM, dwell counter, channel advance, display mux
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    dwell_d     = dwell_q;
    adv         = 1'b0;
    // prescaler free-runs in every state; sec_tick_q mirrors ps_q == PS_LAST
    ps_d        = sec_tick_q ? '0 : ps_q + PS_W'(1);
    sec_tick_d  = (ps_d == PS_LAST);
    btn_d       = next_btn;

    unique case (state_q)
      MANUAL: begin
        if (manual) begin
          if (btn_rise) adv = 1'b1;
        end else if (start) begin
          state_d = AUTO;
          dwell_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      AUTO: begin
        // manual or a falling start pre-empts an advance landing on the same tick
        if (manual)      state_d = MANUAL;
        else if (!start) state_d = IDLE;
        else if (sec_tick_q) begin
          if (dwell_q == DW_LAST) begin
            adv     = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      default: begin
        if (manual) state_d = MANUAL;
        else if (start) begin
          state_d = AUTO;
          dwell_d = '0;
        end
      end
    endcase

    // explicit wrap: NUM_CH need not be a power of two
    if (adv) cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);

    ch_change_d = adv;
    disp_data_d = ch_vec[cur_ch_q];
    disp_alt_d  = ch_alt[cur_ch_q];
  end

  // all state and registered outputs; async reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      ps_q        <= '0;
      dwell_q     <= '0;
      btn_q       <= 1'b0;
      sec_tick_q  <= 1'b0;
      ch_change_q <= 1'b0;
      disp_data_q <= '0;
      disp_alt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      ps_q        <= ps_d;
      dwell_q     <= dwell_d;
      btn_q       <= btn_d;
      sec_tick_q  <= sec_tick_d;
      ch_change_q <= ch_change_d;
      disp_data_q <= disp_data_d;
      disp_alt_q  <= disp_alt_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_alt  = disp_alt_q;
  assign cur_ch    = cur_ch_q;
  assign sec_tick  = sec_tick_q;
  assign ch_change = ch_change_q;

endmodule
